cp0_intc: RTL and testbench

CP0_INTC -- requirements
Module: cp0_intc

---
 rtl/cp0_pkg.sv | 28 ++
 rtl/cp0_sync_bit.sv | 21 ++
 rtl/cp0_intc.sv | 192 +++++++++++++++++++
 tb/tb_cp0_intc.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 interrupt controller: register numbers,
// exception codes, Status/Cause bit positions and the request FSM states.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_BEV   = 22;

  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } irq_state_e;

endpackage

// File: rtl/cp0_sync_bit.sv
// Multi-flop synchroniser for one asynchronous level interrupt line.
module cp0_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw level through the chain; the last flop is the clean copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_intc.sv
// CP0 interrupt controller: Count/Compare timer, Status, Cause and EPC,
// plus a two-state FSM that raises interrupt requests to the pipeline.
//
// Handshake: irq_req is high while the FSM sits in REQ. The pipeline takes
// the interrupt by asserting irq_ack for one cycle while irq_req is high;
// EPC/Cause/EXL update on that edge and irq_req drops the following cycle.
// irq_ack while irq_req is low has no effect. If the interrupt stops being
// enabled before it is taken, irq_req is withdrawn on the next edge.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int NUM_HW_INT  = 6,
  parameter int COUNT_DIV   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMER_LINE  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  mtc0_wen,
  input  logic [4:0]            cp0_waddr,
  input  logic [31:0]           cp0_wdata,
  input  logic [4:0]            cp0_raddr,
  output logic [31:0]           cp0_rdata,
  input  logic                  eret,
  input  logic [31:0]           commit_pc,
  input  logic                  commit_bd,
  output logic                  irq_req,
  input  logic                  irq_ack,
  output logic [31:0]           epc_o,
  output logic                  status_exl,
  output logic                  status_bev,
  output irq_state_e            state_o
);

  logic [5:0]  line_sync;
  logic [5:0]  hw_ip;
  logic [7:0]  pending;
  logic        int_en, tick, take;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  logic [31:0] count_q, count_d, compare_q, compare_d, epc_q, epc_d;
  logic [7:0]  presc_q, presc_d, im_q, im_d;
  logic [4:0]  exc_q, exc_d;
  logic [1:0]  sw_ip_q, sw_ip_d;
  logic        ticked_q, ticked_d, ti_q, ti_d;
  logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  irq_state_e  state_q, state_d;

  // Unused hardware line slots read as zero.
  for (genvar gi = 0; gi < 6; gi++) begin : g_line
    if (gi < NUM_HW_INT) begin : g_used
      cp0_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (hw_int[gi]),
        .q_o   (line_sync[gi])
      );
    end else begin : g_unused
      assign line_sync[gi] = 1'b0;
    end
  end

  assign hw_ip      = line_sync | ({5'b0, ti_q} << TIMER_LINE);
  assign pending    = {hw_ip, sw_ip_q} & im_q;
  assign int_en     = ie_q & ~exl_q & (|pending);
  assign tick       = (presc_q == 8'(COUNT_DIV - 1));
  assign take       = (state_q == S_REQ) && irq_ack;
  assign wr_count   = mtc0_wen && (cp0_waddr == REG_COUNT);
  assign wr_compare = mtc0_wen && (cp0_waddr == REG_COMPARE);
  assign wr_status  = mtc0_wen && (cp0_waddr == REG_STATUS);
  assign wr_cause   = mtc0_wen && (cp0_waddr == REG_CAUSE);
  assign wr_epc     = mtc0_wen && (cp0_waddr == REG_EPC);

  // Register next-state: later assignments carry priority (ack beats eret
  // and mtc0; Compare write beats a timer match; Count write beats a tick).
  always_comb begin
    presc_d   = tick ? 8'd0 : presc_q + 8'd1;
    count_d   = tick ? count_q + 32'd1 : count_q;
    ticked_d  = tick;
    compare_d = compare_q;
    ti_d      = ti_q;
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    sw_ip_d   = sw_ip_q;
    bd_d      = bd_q;
    exc_d     = exc_q;
    epc_d     = epc_q;
    if (wr_count) begin
      presc_d  = 8'd0;
      count_d  = cp0_wdata;
      ticked_d = 1'b0;
    end
    if (ticked_q && (count_q == compare_q)) ti_d = 1'b1;
    if (wr_compare) begin
      compare_d = cp0_wdata;
      ti_d      = 1'b0;
    end
    if (wr_status) begin
      im_d  = cp0_wdata[ST_IM_LO +: 8];
      exl_d = cp0_wdata[ST_EXL];
      ie_d  = cp0_wdata[ST_IE];
    end
    if (wr_cause) sw_ip_d = cp0_wdata[CA_IP_LO +: 2];
    if (wr_epc)   epc_d   = cp0_wdata;
    if (eret)     exl_d   = 1'b0;
    if (take) begin
      epc_d = commit_bd ? commit_pc - 32'd4 : commit_pc;
      bd_d  = commit_bd;
      exc_d = EXC_INT;
      exl_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      presc_q   <= '0;
      ticked_q  <= 1'b0;
      ti_q      <= 1'b0;
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      sw_ip_q   <= '0;
      bd_q      <= 1'b0;
      exc_q     <= '0;
      epc_q     <= '0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      presc_q   <= presc_d;
      ticked_q  <= ticked_d;
      ti_q      <= ti_d;
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      sw_ip_q   <= sw_ip_d;
      bd_q      <= bd_d;
      exc_q     <= exc_d;
      epc_q     <= epc_d;
    end
  end

  // Request FSM next state: raise on enable, drop on ack or withdrawal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (int_en) state_d = S_REQ;
      S_REQ:   if (take || !int_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Combinational register read port.
  always_comb begin
    cp0_rdata = '0;
    case (cp0_raddr)
      REG_COUNT:   cp0_rdata = count_q;
      REG_COMPARE: cp0_rdata = compare_q;
      REG_STATUS: begin
        cp0_rdata[ST_BEV]        = 1'b1;
        cp0_rdata[ST_IM_LO +: 8] = im_q;
        cp0_rdata[ST_EXL]        = exl_q;
        cp0_rdata[ST_IE]         = ie_q;
      end
      REG_CAUSE: begin
        cp0_rdata[CA_BD]          = bd_q;
        cp0_rdata[CA_TI]          = ti_q;
        cp0_rdata[CA_IP_LO +: 8]  = {hw_ip, sw_ip_q};
        cp0_rdata[CA_EXC_LO +: 5] = exc_q;
      end
      REG_EPC:     cp0_rdata = epc_q;
      default:     cp0_rdata = '0;
    endcase
  end

  assign irq_req    = (state_q == S_REQ);
  assign epc_o      = epc_q;
  assign status_exl = exl_q;
  assign status_bev = 1'b1;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: a driver pushes expected values into a queue
// and strobes chk_valid; a monitor on the falling edge pops and compares.
module tb_cp0_intc;
  import cp0_pkg::*;

  localparam int SEL_RDATA = 0;
  localparam int SEL_IRQ   = 1;
  localparam int SEL_EPC   = 2;
  localparam int SEL_EXL   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  hw_int;
  logic        mtc0_wen;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        eret;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic        irq_req;
  logic        irq_ack;
  logic [31:0] epc_o;
  logic        status_exl;
  logic        status_bev;
  irq_state_e  state_o;

  cp0_intc dut (
    .clk        (clk),
    .reset      (reset),
    .hw_int     (hw_int),
    .mtc0_wen   (mtc0_wen),
    .cp0_waddr  (cp0_waddr),
    .cp0_wdata  (cp0_wdata),
    .cp0_raddr  (cp0_raddr),
    .cp0_rdata  (cp0_rdata),
    .eret       (eret),
    .commit_pc  (commit_pc),
    .commit_bd  (commit_bd),
    .irq_req    (irq_req),
    .irq_ack    (irq_ack),
    .epc_o      (epc_o),
    .status_exl (status_exl),
    .status_bev (status_bev),
    .state_o    (state_o)
  );

  // Clock.
  always #5 clk = ~clk;

  // Scoreboard.
  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  logic        chk_valid = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_exp, m_act;
  int          m_sel;
  string       m_name;

  task automatic expect_reg(input logic [4:0] addr, input logic [31:0] val, input string name);
    cp0_raddr = addr;
    exp_q.push_back(val);
    sel_q.push_back(SEL_RDATA);
    name_q.push_back(name);
  endtask

  task automatic expect_sig(input int sel, input logic [31:0] val, input string name);
    exp_q.push_back(val);
    sel_q.push_back(sel);
    name_q.push_back(name);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    mtc0_wen  = 1'b1;
    cp0_waddr = addr;
    cp0_wdata = data;
  endtask

  // One clock: pending expectations are sampled before the edge.
  task automatic tick();
    chk_valid = (exp_q.size() != 0);
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    mtc0_wen  = 1'b0;
    eret      = 1'b0;
    irq_ack   = 1'b0;
  endtask

  // Monitor.
  always @(negedge clk) begin
    if (chk_valid) begin
      while (exp_q.size() != 0) begin
        m_exp  = exp_q.pop_front();
        m_sel  = sel_q.pop_front();
        m_name = name_q.pop_front();
        case (m_sel)
          SEL_RDATA: m_act = cp0_rdata;
          SEL_IRQ:   m_act = {31'b0, irq_req};
          SEL_EPC:   m_act = epc_o;
          default:   m_act = {31'b0, status_exl};
        endcase
        checks++;
        if (m_act !== m_exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", m_name, m_act, m_exp);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    hw_int = '0; mtc0_wen = 1'b0; cp0_waddr = '0; cp0_wdata = '0; cp0_raddr = '0;
    eret = 1'b0; commit_pc = '0; commit_bd = 1'b0; irq_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    expect_reg(REG_COUNT, 32'h0, "reset_count"); expect_sig(SEL_IRQ, 0, "reset_irq"); tick();
    expect_reg(REG_STATUS, 32'h0040_0000, "reset_status"); expect_sig(SEL_EXL, 0, "reset_exl"); tick();
    expect_reg(REG_CAUSE, 32'h0, "reset_cause"); expect_sig(SEL_EPC, 0, "reset_epc"); tick();
    expect_reg(REG_COMPARE, 32'h0, "reset_compare"); tick();
    expect_reg(5'd8, 32'h0, "unmapped_read"); tick();

    // Timer match raises IP7 and a request.
    mtc0(REG_COMPARE, 32'd10); tick();
    mtc0(REG_STATUS, 32'h0000_8001); tick();
    mtc0(REG_COUNT, 32'd0); tick();
    repeat (19) tick();
    expect_reg(REG_COUNT, 32'd9, "timer_count9"); tick();
    expect_reg(REG_COUNT, 32'd10, "timer_count10"); expect_sig(SEL_IRQ, 0, "timer_irq_pre"); tick();
    expect_reg(REG_CAUSE, 32'h4000_8000, "timer_cause_ti"); expect_sig(SEL_IRQ, 0, "timer_irq_ti"); tick();
    expect_reg(REG_COUNT, 32'd11, "timer_count11"); expect_sig(SEL_IRQ, 1, "timer_irq_req"); tick();

    // Acknowledge from a delay slot.
    irq_ack = 1'b1; commit_pc = 32'h8000_1000; commit_bd = 1'b1; tick();
    expect_reg(REG_EPC, 32'h8000_0FFC, "ack_epc"); expect_sig(SEL_IRQ, 0, "ack_irq_drop");
    expect_sig(SEL_EXL, 1, "ack_exl"); tick();
    expect_reg(REG_CAUSE, 32'hC000_8000, "ack_cause"); tick();
    expect_reg(REG_STATUS, 32'h0040_8003, "ack_status"); expect_sig(SEL_IRQ, 0, "ack_irq_exl_block"); tick();

    // ERET reopens the sticky timer interrupt; then ack + eret + EPC write.
    eret = 1'b1; tick();
    expect_sig(SEL_EXL, 0, "eret_exl"); expect_sig(SEL_IRQ, 0, "eret_irq_pre"); tick();
    expect_sig(SEL_IRQ, 1, "eret_rerequest"); tick();
    irq_ack = 1'b1; eret = 1'b1; commit_pc = 32'h0000_0200; commit_bd = 1'b0;
    mtc0(REG_EPC, 32'hDEAD_0000); tick();
    expect_sig(SEL_EXL, 1, "ack_eret_exl"); expect_sig(SEL_EPC, 32'h200, "ack_mtc0_epc");
    expect_sig(SEL_IRQ, 0, "ack2_irq"); expect_reg(REG_CAUSE, 32'h4000_8000, "ack2_cause_bd0"); tick();

    // Compare write clears TI.
    mtc0(REG_COMPARE, 32'h7FFF_0000); tick();
    expect_reg(REG_CAUSE, 32'h0, "compare_clears_ti"); tick();

    // Compare write on the match cycle; Count write on a tick; wrap.
    mtc0(REG_COMPARE, 32'h51); tick();
    mtc0(REG_COUNT, 32'h50); tick();
    tick(); tick();
    mtc0(REG_COMPARE, 32'h51); tick();
    expect_reg(REG_CAUSE, 32'h0, "match_clear_wins"); mtc0(REG_COUNT, 32'h1234); tick();
    expect_reg(REG_COUNT, 32'h1234, "count_write_wins"); tick();
    mtc0(REG_COUNT, 32'hFFFF_FFFF); tick();
    expect_reg(REG_COUNT, 32'hFFFF_FFFF, "count_max"); tick();
    tick();
    expect_reg(REG_COUNT, 32'h0, "count_wrap"); tick();
    tick();
    mtc0(REG_COUNT, 32'h4000_0000); tick();
    tick();
    expect_reg(REG_COUNT, 32'h4000_0000, "count_write_clears_presc"); tick();

    // Hardware line request withdrawn by masking.
    mtc0(REG_STATUS, 32'h0000_0401); tick();
    hw_int[0] = 1'b1; tick(); tick();
    expect_reg(REG_CAUSE, 32'h0000_0400, "hw0_ip2"); expect_sig(SEL_IRQ, 0, "hw0_irq_pre"); tick();
    expect_sig(SEL_IRQ, 1, "hw0_irq_req"); mtc0(REG_STATUS, 32'h0000_0001); tick();
    tick();
    expect_sig(SEL_IRQ, 0, "withdraw_irq"); expect_reg(REG_EPC, 32'h200, "withdraw_epc"); tick();
    irq_ack = 1'b1; commit_pc = 32'h1234_5678; tick();
    expect_sig(SEL_EPC, 32'h200, "idle_ack_epc"); expect_sig(SEL_EXL, 0, "idle_ack_exl"); tick();

    // Reset in the middle of a request.
    mtc0(REG_STATUS, 32'h0000_0401); tick();
    tick();
    expect_sig(SEL_IRQ, 1, "pre_reset_irq"); tick();
    #2 reset = 1'b1;
    expect_sig(SEL_IRQ, 0, "reset_async_irq"); expect_reg(REG_STATUS, 32'h0040_0000, "reset_async_status");
    expect_sig(SEL_EPC, 32'h0, "reset_async_epc"); tick();
    reset = 1'b0; hw_int = '0; tick(); tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
